apb_i2c_cmd_sequencer: RTL and testbench

//  APB master that sequences complete I2C transfers through the APB-to-I2C bridge.

---
 rtl/apb_i2c_cmd_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_apb_i2c_cmd_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_i2c_cmd_sequencer.sv
// APB master that runs one complete I2C transfer through the APB-to-I2C bridge:
// program CONFIG, program TIMEOUT, then push bytes to the TX FIFO or pull bytes
// from the RX FIFO, finishing with a one-cycle done or err pulse.
//
// Handshakes: a command is taken on the cycle where cmd_valid and cmd_ready are
// both high (cmd_ready is high only in IDLE). A write byte is taken on the cycle
// where wr_valid is high in DAT_W; wr_ready pulses in that same cycle. rd_valid
// pulses in the cycle the read access completes and rd_data holds that byte
// until the next rd_valid. Neither stream has back-pressure toward this block.
module apb_i2c_cmd_sequencer #(
  parameter int MAX_BYTES  = 16,
  parameter int WAIT_LIMIT = 255,
  localparam int LW = $clog2(MAX_BYTES + 1)
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [13:0]   cmd_config,
  input  logic [13:0]   cmd_timeout,
  input  logic [LW-1:0] cmd_len,
  input  logic          wr_valid,
  input  logic [31:0]   wr_data,
  output logic          wr_ready,
  output logic          rd_valid,
  output logic [31:0]   rd_data,
  output logic          done,
  output logic          err,
  output logic          PSELx,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [31:0]   PADDR,
  output logic [31:0]   PWDATA,
  input  logic [31:0]   PRDATA,
  input  logic          PREADY,
  input  logic          PSLVERR,
  input  logic          INT_RX,
  output logic [3:0]    dbg_state
);

  // The wait counter only has to hold 0..WAIT_LIMIT-1; hitting the last value
  // with PREADY still low is the abort condition.
  localparam int WW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_LIMIT - 1);
  localparam logic [LW-1:0] MAX_LEN   = LW'(MAX_BYTES);

  localparam logic [31:0] ADDR_TX   = 32'h0;
  localparam logic [31:0] ADDR_RX   = 32'h4;
  localparam logic [31:0] ADDR_CFG  = 32'h8;
  localparam logic [31:0] ADDR_TMO  = 32'hC;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CFG_S = 4'd1,
    S_CFG_A = 4'd2,
    S_TMO_S = 4'd3,
    S_TMO_A = 4'd4,
    S_DAT_W = 4'd5,
    S_DAT_S = 4'd6,
    S_DAT_A = 4'd7,
    S_DONE  = 4'd8,
    S_ERR   = 4'd9
  } state_t;

  state_t          state, state_nxt;
  logic            write_q;
  logic [13:0]     cfg_q;
  logic [13:0]     tmo_q;
  logic [LW-1:0]   remaining;
  logic [31:0]     wdata_q;
  logic [31:0]     rd_q;
  logic [WW-1:0]   wait_cnt;
  logic            acc_ok;
  logic            acc_fail;
  logic            in_setup;

  assign dbg_state = state;
  assign acc_ok    = PREADY && !PSLVERR;
  assign acc_fail  = (PREADY && PSLVERR) || (!PREADY && (wait_cnt == WAIT_LAST));
  assign in_setup  = (state == S_CFG_S) || (state == S_TMO_S) || (state == S_DAT_S);

  // cmd_ready stays low while reset is held so nothing is offered before release.
  assign cmd_ready = (state == S_IDLE) && PRESETn;
  assign wr_ready  = (state == S_DAT_W) && write_q && wr_valid;
  assign rd_valid  = (state == S_DAT_A) && !write_q && acc_ok;
  assign rd_data   = rd_valid ? PRDATA : rd_q;
  assign done      = (state == S_DONE);
  assign err       = (state == S_ERR);

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state: each access state either holds, advances on a clean completion,
  // or aborts on slave error / wait-limit expiry.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_valid) state_nxt = (cmd_len > MAX_LEN) ? S_ERR : S_CFG_S;
      S_CFG_S: state_nxt = S_CFG_A;
      S_CFG_A: begin
        if (acc_fail)    state_nxt = S_ERR;
        else if (acc_ok) state_nxt = S_TMO_S;
      end
      S_TMO_S: state_nxt = S_TMO_A;
      S_TMO_A: begin
        if (acc_fail)    state_nxt = S_ERR;
        else if (acc_ok) state_nxt = (remaining == '0) ? S_DONE : S_DAT_W;
      end
      S_DAT_W: begin
        if (write_q ? wr_valid : !INT_RX) state_nxt = S_DAT_S;
      end
      S_DAT_S: state_nxt = S_DAT_A;
      S_DAT_A: begin
        if (acc_fail)    state_nxt = S_ERR;
        else if (acc_ok) state_nxt = (remaining == LW'(1)) ? S_DONE : S_DAT_W;
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // APB drive: address, direction and data are a pure function of the state so
  // they are stable across setup and access and drop to zero everywhere else.
  always_comb begin
    PSELx   = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    case (state)
      S_CFG_S, S_CFG_A: begin
        PSELx   = 1'b1;
        PENABLE = (state == S_CFG_A);
        PWRITE  = 1'b1;
        PADDR   = ADDR_CFG;
        PWDATA  = {18'b0, cfg_q};
      end
      S_TMO_S, S_TMO_A: begin
        PSELx   = 1'b1;
        PENABLE = (state == S_TMO_A);
        PWRITE  = 1'b1;
        PADDR   = ADDR_TMO;
        PWDATA  = {18'b0, tmo_q};
      end
      S_DAT_S, S_DAT_A: begin
        PSELx   = 1'b1;
        PENABLE = (state == S_DAT_A);
        PWRITE  = write_q;
        PADDR   = write_q ? ADDR_TX : ADDR_RX;
        PWDATA  = write_q ? wdata_q : 32'h0;
      end
      default: ;
    endcase
  end

  // Command fields, byte counter, write-byte holding register, read-data hold
  // register and the per-access wait counter.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      write_q   <= 1'b0;
      cfg_q     <= '0;
      tmo_q     <= '0;
      remaining <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      wait_cnt  <= '0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        write_q   <= cmd_write;
        cfg_q     <= cmd_config;
        tmo_q     <= cmd_timeout;
        remaining <= cmd_len;
      end
      if (wr_ready) wdata_q <= wr_data;
      if (rd_valid) rd_q <= PRDATA;
      // DAT_A is only entered with remaining >= 1, so this never wraps.
      if (state == S_DAT_A && acc_ok) remaining <= remaining - 1'b1;
      if (in_setup) begin
        wait_cnt <= '0;
      end else if (PENABLE && !PREADY && (wait_cnt != WAIT_LAST)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_i2c_cmd_sequencer.sv
// Bench for apb_i2c_cmd_sequencer: a command model expands each command into
// the expected event stream (APB completions, wr_ready, rd_valid, done, err)
// and into a plan for the APB slave; a negedge monitor pops and compares.
module tb_apb_i2c_cmd_sequencer;

  localparam int LW = 5;
  localparam int MAXB = 16;
  localparam int WL = 8;

  localparam int K_APB = 1, K_RDV = 2, K_WRR = 3, K_DONE = 4, K_ERR = 5;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [13:0]   cmd_config, cmd_timeout;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready;
  logic [31:0]   wr_data;
  logic          rd_valid;
  logic [31:0]   rd_data;
  logic          done, err;
  logic          PSELx, PENABLE, PWRITE;
  logic [31:0]   PADDR, PWDATA, PRDATA;
  logic          PREADY, PSLVERR, INT_RX;
  logic [3:0]    dbg_state;

  apb_i2c_cmd_sequencer #(.MAX_BYTES(MAXB), .WAIT_LIMIT(WL)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_config(cmd_config), .cmd_timeout(cmd_timeout), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .INT_RX(INT_RX), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 PCLK = ~PCLK;

  // ---------------- scoreboard state ----------------
  typedef struct {
    int          w;
    bit          e;
    logic [31:0] d;
  } plan_t;

  logic [63:0] exp_q[$];
  plan_t       plan_q[$];
  logic [39:0] wr_src_q[$];
  logic [31:0] dat_ovr[$];
  int n_cmp = 0;
  int n_fail = 0;

  bit          c_wr;
  logic [13:0] c_cfg, c_tmo;
  int          c_len;
  int          rx_lo = 0, rx_hi = 0, rx_cnt = 0;

  function automatic logic [63:0] mk_ev(input int kind, input bit e, input bit w,
                                        input logic [15:0] a, input logic [31:0] d);
    return {4'(kind), e, w, 10'b0, a, d};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, got, want);
    end
  endtask

  task automatic check_ev(input logic [63:0] got, input string nm);
    logic [63:0] want;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got event 0x%0h, none expected", nm, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s: got event 0x%0h want 0x%0h", nm, got, want);
      end
    end
  endtask

  // ---------------- APB slave: follows the plan queue per access ----------------
  int          sw;
  bit          se, s_active;
  logic [31:0] sd;
  initial begin
    PREADY = 0; PSLVERR = 0; PRDATA = 0; s_active = 0;
    forever begin
      @(posedge PCLK); #2;
      if (PSELx && PENABLE) begin
        if (!s_active) begin
          s_active = 1;
          if (plan_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL apb_unplanned: access at 0x%0h, planned none", PADDR);
            sw = 0; se = 0; sd = $urandom;
          end else begin
            sw = plan_q[0].w; se = plan_q[0].e; sd = plan_q[0].d;
            void'(plan_q.pop_front());
          end
        end
        if (sw == 0) begin
          PREADY = 1; PSLVERR = se; PRDATA = sd;
        end else begin
          sw--; PREADY = 0; PSLVERR = 1'($urandom_range(0, 1)); PRDATA = $urandom;
        end
      end else begin
        // Outside the access phase the slave lines are noise.
        s_active = 0;
        PREADY = 1'($urandom_range(0, 1)); PSLVERR = 1'($urandom_range(0, 1)); PRDATA = $urandom;
      end
    end
  end

  // ---------------- write-byte source with idle-cycle stalls ----------------
  bit wr_hs;
  initial begin
    wr_valid = 0; wr_data = 0;
    forever begin
      @(negedge PCLK); wr_hs = wr_valid && wr_ready;
      @(posedge PCLK); #1;
      if (wr_hs && wr_src_q.size() != 0) begin
        void'(wr_src_q.pop_front()); wr_valid = 0; wr_data = $urandom;
      end
      if (!wr_valid && wr_src_q.size() != 0 && !PSELx) begin
        if (wr_src_q[0][39:32] != 8'd0) wr_src_q[0][39:32] = wr_src_q[0][39:32] - 8'd1;
        else begin wr_valid = 1; wr_data = wr_src_q[0][31:0]; end
      end
    end
  end

  // ---------------- RX FIFO empty flag: goes empty after each read ----------------
  initial begin
    INT_RX = 1;
    forever begin
      @(posedge PCLK); #1;
      if (PSELx && !PENABLE && !PWRITE && PADDR == 32'h4) rx_cnt = $urandom_range(rx_lo, rx_hi);
      if (PSELx) INT_RX = (rx_cnt != 0) ? 1'b1 : 1'($urandom_range(0, 1));
      else if (rx_cnt != 0) begin INT_RX = 1; rx_cnt--; end
      else INT_RX = 0;
    end
  end

  // ---------------- monitor ----------------
  int          cyc = 0, last_cmpl = 0, acc_run = 0;
  logic [31:0] su_addr, su_data;
  logic        su_wr, prev_int_rx = 1'b1;
  always @(negedge PCLK) begin
    if (!PRESETn) begin
      acc_run = 0;
    end else begin
      cyc++;
      if (PSELx && !PENABLE) begin
        acc_run = 0; su_addr = PADDR; su_wr = PWRITE; su_data = PWDATA;
        if (!PWRITE && PADDR == 32'h4) chk("rd_gated_by_int_rx", 64'(prev_int_rx), 64'(0));
      end
      if (PSELx && PENABLE) begin
        acc_run++;
        if (PREADY) begin
          chk("apb_hold", {PADDR[30:0], PWRITE, PWRITE ? PWDATA : 32'h0},
                          {su_addr[30:0], su_wr, su_wr ? su_data : 32'h0});
          check_ev(mk_ev(K_APB, PSLVERR, PWRITE, PADDR[15:0], PWRITE ? PWDATA : 32'h0), "apb_xfer");
          last_cmpl = cyc;
        end
      end
      if (rd_valid) check_ev(mk_ev(K_RDV, 0, 0, 16'h0, rd_data), "rd_valid");
      if (wr_ready) check_ev(mk_ev(K_WRR, 0, 1, 16'h0, wr_data), "wr_ready");
      if (done) begin
        check_ev(mk_ev(K_DONE, 0, 0, 16'h0, 32'h0), "done");
        chk("done_latency", 64'(cyc - last_cmpl), 64'(1));
        acc_run = 0;
      end
      if (err) begin
        check_ev(mk_ev(K_ERR, 0, 0, 16'h0, 32'(acc_run)), "err");
        acc_run = 0;
      end
      prev_int_rx = INT_RX;
    end
  end

  // ---------------- command model: expands a command into expected events ----------------
  task automatic plan_cmd(input bit wr, input logic [13:0] cfg, input logic [13:0] tmo,
                          input int len, input int fidx, input bit fto,
                          input int wlo, input int whi, input int slo, input int shi);
    plan_t       p;
    logic [15:0] a;
    logic [31:0] d;
    bit          is_wr;
    c_wr = wr; c_cfg = cfg; c_tmo = tmo; c_len = len;
    rx_lo = slo; rx_hi = shi; rx_cnt = $urandom_range(slo, shi);
    if (len > MAXB) begin
      exp_q.push_back(mk_ev(K_ERR, 0, 0, 16'h0, 32'h0));
    end else begin
      for (int i = 0; i < len + 2; i++) begin
        if (i == 0)      begin a = 16'h8; d = {18'b0, cfg}; is_wr = 1; end
        else if (i == 1) begin a = 16'hC; d = {18'b0, tmo}; is_wr = 1; end
        else begin
          a = wr ? 16'h0 : 16'h4; is_wr = wr;
          d = (dat_ovr.size() != 0) ? dat_ovr.pop_front() : $urandom;
        end
        p.w = $urandom_range(wlo, whi); p.e = 0; p.d = d;
        if (i == fidx) begin
          if (fto) p.w = 3 * WL; else p.e = 1;
        end
        plan_q.push_back(p);
        if (i >= 2 && wr) begin
          wr_src_q.push_back({8'($urandom_range(slo, shi)), d});
          exp_q.push_back(mk_ev(K_WRR, 0, 1, 16'h0, d));
        end
        if (i == fidx && fto) begin
          exp_q.push_back(mk_ev(K_ERR, 0, 0, 16'h0, 32'(WL)));
          break;
        end
        exp_q.push_back(mk_ev(K_APB, p.e, is_wr, a, is_wr ? d : 32'h0));
        if (p.e) begin
          exp_q.push_back(mk_ev(K_ERR, 0, 0, 16'h0, 32'(p.w + 1)));
          break;
        end
        if (i >= 2 && !wr) exp_q.push_back(mk_ev(K_RDV, 0, 0, 16'h0, d));
        if (i == len + 1) exp_q.push_back(mk_ev(K_DONE, 0, 0, 16'h0, 32'h0));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue_cmd();
    int t;
    @(posedge PCLK); #1;
    cmd_valid = 1; cmd_write = c_wr; cmd_config = c_cfg; cmd_timeout = c_tmo; cmd_len = LW'(c_len);
    t = 0;
    do begin @(negedge PCLK); t++; end while (!cmd_ready && t < 50);
    chk("cmd_accept", 64'(cmd_ready), 64'(1));
    @(posedge PCLK); #1;
    // Fields are latched on accept; scramble them to prove they are no longer used.
    cmd_valid = 0; cmd_write = ~c_wr; cmd_config = 14'($urandom);
    cmd_timeout = 14'($urandom); cmd_len = LW'($urandom);
  endtask

  task automatic flush();
    exp_q.delete(); plan_q.delete(); wr_src_q.delete(); dat_ovr.delete();
    wr_valid = 0;
  endtask

  task automatic finish_cmd(input string nm);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin @(negedge PCLK); t++; end
    chk({nm, "_complete"}, 64'(exp_q.size()), 64'(0));
    @(negedge PCLK);
    chk({nm, "_ready_after"}, 64'(cmd_ready), 64'(1));
    repeat (2) @(negedge PCLK);
    chk({nm, "_plan_used"}, 64'(plan_q.size()), 64'(0));
    flush();
  endtask

  task automatic run_cmd(input string nm, input bit wr, input logic [13:0] cfg, input logic [13:0] tmo,
                         input int len, input int fidx, input bit fto,
                         input int wlo, input int whi, input int slo, input int shi);
    plan_cmd(wr, cfg, tmo, len, fidx, fto, wlo, whi, slo, shi);
    issue_cmd();
    finish_cmd(nm);
  endtask

  // ---------------- reset + stimulus ----------------
  initial begin
    int t, len, r, fidx;
    bit wr;
    PRESETn = 0; cmd_valid = 0; cmd_write = 0; cmd_config = 0; cmd_timeout = 0; cmd_len = 0;
    #3;
    chk("reset_apb", {PADDR, PWDATA}, 64'h0);
    chk("reset_ctl", {24'b0, PSELx, PENABLE, PWRITE, wr_ready, rd_valid, done, err, cmd_ready, rd_data}, 64'h0);
    #20 PRESETn = 1;
    @(negedge PCLK);
    chk("ready_after_reset", 64'(cmd_ready), 64'(1));

    // Write of two bytes, zero-wait slave.
    run_cmd("t1_write2", 1, 14'h0123, 14'h0040, 2, -1, 0, 0, 0, 0, 0);
    // Read of three bytes with fixed FIFO contents.
    dat_ovr.push_back(32'hA5); dat_ovr.push_back(32'h5A); dat_ovr.push_back(32'hFF);
    run_cmd("t2_read3", 0, 14'($urandom), 14'($urandom), 3, -1, 0, 0, 0, 0, 0);
    // Zero-length commands in both directions.
    run_cmd("t3_len0_wr", 1, 14'($urandom), 14'($urandom), 0, -1, 0, 0, 2, 0, 0);
    run_cmd("t3_len0_rd", 0, 14'($urandom), 14'($urandom), 0, -1, 0, 0, 2, 0, 0);
    // Slave error on the second data write.
    run_cmd("t4_slverr", 1, 14'($urandom), 14'($urandom), 4, 3, 0, 0, 2, 0, 2);
    // Wait-limit expiry on CFG and on a data write; longest legal wait and stalls.
    run_cmd("t5_tmo_cfg", 1, 14'($urandom), 14'($urandom), 2, 0, 1, 0, 0, 0, 0);
    run_cmd("t5_tmo_dat", 1, 14'($urandom), 14'($urandom), 3, 2, 1, 0, 1, 0, 1);
    run_cmd("t5_wait7_wr", 1, 14'($urandom), 14'($urandom), 2, -1, 0, WL - 1, WL - 1, 7, 7);
    run_cmd("t5_stall7_rd", 0, 14'($urandom), 14'($urandom), 3, -1, 0, 0, WL - 1, 7, 7);
    // Oversized length goes straight to err.
    run_cmd("t_len17", 1, 14'($urandom), 14'($urandom), MAXB + 1, -1, 0, 0, 0, 0, 0);
    run_cmd("t_len16", 0, 14'($urandom), 14'($urandom), MAXB, -1, 0, 0, 1, 0, 1);

    // Reset while the TIMEOUT access is stalled.
    plan_cmd(1, 14'($urandom), 14'($urandom), 2, -1, 0, 6, 6, 0, 0);
    issue_cmd();
    t = 0;
    while (!(PSELx && PENABLE && PADDR == 32'hC) && t < 100) begin @(negedge PCLK); t++; end
    chk("t6_reached_tmo_a", 64'(PSELx && PENABLE && PADDR == 32'hC), 64'(1));
    #2 PRESETn = 0;
    #1;
    chk("t6_reset_apb", {PADDR, PWDATA}, 64'h0);
    chk("t6_reset_ctl", {24'b0, PSELx, PENABLE, PWRITE, wr_ready, rd_valid, done, err, cmd_ready, rd_data}, 64'h0);
    flush();
    repeat (3) @(posedge PCLK);
    #3 PRESETn = 1;
    @(negedge PCLK);
    chk("t6_ready_after", 64'(cmd_ready), 64'(1));
    run_cmd("t6_after_reset", 0, 14'($urandom), 14'($urandom), 2, -1, 0, 0, 3, 0, 3);

    // Randomized commands.
    for (int k = 0; k < 30; k++) begin
      wr = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(MAXB + 1, 31) : $urandom_range(0, MAXB);
      r = $urandom_range(0, 9);
      fidx = (r < 2 && len <= MAXB) ? $urandom_range(0, len + 1) : -1;
      run_cmd("rand", wr, 14'($urandom), 14'($urandom), len, fidx, r == 0, 0, WL - 1, 0, 7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
